// File: rtl/soc_mem_pkg.sv
// Shared constants for the SoC memory subsystem: arbitration modes, port ids, default widths.
package soc_mem_pkg;

   localparam int unsigned ARB_RR     = 0;
   localparam int unsigned ARB_FIXED  = 1;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned DEF_DATA_W = 8;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating wait counter; flags starvation once port 1 has been refused MAX_WAIT cycles.
module arb_starve_counter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic starve
);

   // Keep a 1-bit counter when the guard is disabled so the vector is never zero-width.
   localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CntW'(MAX_WAIT))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign starve = (MAX_WAIT != 0) && (cnt_q == CntW'(MAX_WAIT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared single-port 256x8 memory: grant, address mux and read return.
module mem_arbiter
   import soc_mem_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ARB_MODE = ARB_RR,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_strobe,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic last_q, last_d;
   logic rd_pend_q, rd_pend_d;
   logic rd_port_q, rd_port_d;
   logic starve;
   logic cnt_inc, cnt_clr;

   always_comb begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
      if (!reset) begin
         if (ARB_MODE == ARB_FIXED) begin
            if (p1_req && (starve || !p0_req)) begin
               p1_gnt = 1'b1;
            end else if (p0_req) begin
               p0_gnt = 1'b1;
            end
         end else begin
            // On a tie the port that was not served last wins.
            if (p0_req && p1_req) begin
               if (last_q == PORT_CPU) begin
                  p1_gnt = 1'b1;
               end else begin
                  p0_gnt = 1'b1;
               end
            end else begin
               p0_gnt = p0_req;
               p1_gnt = p1_req;
            end
         end
      end
   end

   always_comb begin
      mem_addr  = p0_addr;
      mem_we    = p0_we & p0_gnt;
      mem_wdata = p0_wdata;
      if (p1_gnt) begin
         mem_addr  = p1_addr;
         mem_we    = p1_we;
         mem_wdata = p1_wdata;
      end
   end

   assign mem_strobe = p0_gnt | p1_gnt;

   always_comb begin
      last_d = last_q;
      if (p1_gnt) begin
         last_d = PORT_LDR;
      end else if (p0_gnt) begin
         last_d = PORT_CPU;
      end
      rd_pend_d = mem_strobe & ~mem_we;
      rd_port_d = p1_gnt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q    <= PORT_LDR;
         rd_pend_q <= 1'b0;
         rd_port_q <= PORT_CPU;
      end else begin
         last_q    <= last_d;
         rd_pend_q <= rd_pend_d;
         rd_port_q <= rd_port_d;
      end
   end

   assign p0_rvalid = rd_pend_q & (rd_port_q == PORT_CPU);
   assign p1_rvalid = rd_pend_q & (rd_port_q == PORT_LDR);
   assign p0_rdata  = mem_rdata;
   assign p1_rdata  = mem_rdata;

   // The counter is held cleared in round-robin mode.
   assign cnt_inc = p1_req & ~p1_gnt;
   assign cnt_clr = (ARB_MODE != ARB_FIXED) | p1_gnt | ~p1_req;

   arb_starve_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk    (clk),
      .reset  (reset),
      .inc    (cnt_inc),
      .clr    (cnt_clr),
      .starve (starve)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: round-robin and fixed-priority arbiters, each with a behavioural memory.
module tb_mem_arbiter;
   import soc_mem_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] gnt;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } gexp_t;

   typedef struct packed {
      logic       port;
      logic [7:0] data;
   } rexp_t;

   gexp_t gq_r[$], gq_f[$];
   rexp_t rq_r[$], rq_f[$];
   int vectors = 0;
   int errors  = 0;

   logic       r_reset, r_p0_req, r_p0_we, r_p1_req, r_p1_we;
   logic [7:0] r_p0_addr, r_p0_wdata, r_p1_addr, r_p1_wdata;
   logic       r_p0_gnt, r_p0_rvalid, r_p1_gnt, r_p1_rvalid;
   logic [7:0] r_p0_rdata, r_p1_rdata, r_mem_addr, r_mem_wdata, r_mem_rdata;
   logic       r_mem_strobe, r_mem_we;

   logic       f_reset, f_p0_req, f_p0_we, f_p1_req, f_p1_we;
   logic [7:0] f_p0_addr, f_p0_wdata, f_p1_addr, f_p1_wdata;
   logic       f_p0_gnt, f_p0_rvalid, f_p1_gnt, f_p1_rvalid;
   logic [7:0] f_p0_rdata, f_p1_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
   logic       f_mem_strobe, f_mem_we;

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .ARB_MODE(ARB_RR), .MAX_WAIT(4)) u_rr (
      .clk(clk), .reset(r_reset),
      .p0_req(r_p0_req), .p0_we(r_p0_we), .p0_addr(r_p0_addr), .p0_wdata(r_p0_wdata),
      .p0_gnt(r_p0_gnt), .p0_rvalid(r_p0_rvalid), .p0_rdata(r_p0_rdata),
      .p1_req(r_p1_req), .p1_we(r_p1_we), .p1_addr(r_p1_addr), .p1_wdata(r_p1_wdata),
      .p1_gnt(r_p1_gnt), .p1_rvalid(r_p1_rvalid), .p1_rdata(r_p1_rdata),
      .mem_addr(r_mem_addr), .mem_strobe(r_mem_strobe), .mem_we(r_mem_we),
      .mem_wdata(r_mem_wdata), .mem_rdata(r_mem_rdata)
   );

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .ARB_MODE(ARB_FIXED), .MAX_WAIT(4)) u_fx (
      .clk(clk), .reset(f_reset),
      .p0_req(f_p0_req), .p0_we(f_p0_we), .p0_addr(f_p0_addr), .p0_wdata(f_p0_wdata),
      .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid), .p0_rdata(f_p0_rdata),
      .p1_req(f_p1_req), .p1_we(f_p1_we), .p1_addr(f_p1_addr), .p1_wdata(f_p1_wdata),
      .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid), .p1_rdata(f_p1_rdata),
      .mem_addr(f_mem_addr), .mem_strobe(f_mem_strobe), .mem_we(f_mem_we),
      .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata)
   );

   // Unwritten locations read back their own address.
   logic [7:0]   mem_r [256];
   logic [7:0]   mem_f [256];
   logic [255:0] wr_r = '0;
   logic [255:0] wr_f = '0;

   always @(posedge clk) begin
      if (r_mem_strobe) begin
         if (r_mem_we) begin
            mem_r[r_mem_addr] <= r_mem_wdata;
            wr_r[r_mem_addr]  <= 1'b1;
         end else begin
            r_mem_rdata <= wr_r[r_mem_addr] ? mem_r[r_mem_addr] : r_mem_addr;
         end
      end
   end

   always @(posedge clk) begin
      if (f_mem_strobe) begin
         if (f_mem_we) begin
            mem_f[f_mem_addr] <= f_mem_wdata;
            wr_f[f_mem_addr]  <= 1'b1;
         end else begin
            f_mem_rdata <= wr_f[f_mem_addr] ? mem_f[f_mem_addr] : f_mem_addr;
         end
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      gexp_t ge;
      rexp_t re;
      if (gq_r.size() > 0) begin
         ge = gq_r.pop_front();
         cmp("rr_gnt", {r_p1_gnt, r_p0_gnt}, ge.gnt);
         cmp("rr_strobe", r_mem_strobe, |ge.gnt);
         cmp("rr_we", r_mem_we, ge.we);
         cmp("rr_addr", r_mem_addr, ge.addr);
         cmp("rr_wdata", r_mem_wdata, ge.wdata);
      end
      if (r_p0_rvalid || r_p1_rvalid) begin
         if (rq_r.size() == 0) begin
            cmp("rr_unexpected_rvalid", {r_p1_rvalid, r_p0_rvalid}, 2'b00);
         end else begin
            re = rq_r.pop_front();
            cmp("rr_rvalid", {r_p1_rvalid, r_p0_rvalid}, re.port ? 2'b10 : 2'b01);
            cmp("rr_rdata", re.port ? r_p1_rdata : r_p0_rdata, re.data);
         end
      end
   end

   always @(negedge clk) begin
      gexp_t ge;
      rexp_t re;
      if (gq_f.size() > 0) begin
         ge = gq_f.pop_front();
         cmp("fx_gnt", {f_p1_gnt, f_p0_gnt}, ge.gnt);
         cmp("fx_strobe", f_mem_strobe, |ge.gnt);
         cmp("fx_we", f_mem_we, ge.we);
         cmp("fx_addr", f_mem_addr, ge.addr);
         cmp("fx_wdata", f_mem_wdata, ge.wdata);
      end
      if (f_p0_rvalid || f_p1_rvalid) begin
         if (rq_f.size() == 0) begin
            cmp("fx_unexpected_rvalid", {f_p1_rvalid, f_p0_rvalid}, 2'b00);
         end else begin
            re = rq_f.pop_front();
            cmp("fx_rvalid", {f_p1_rvalid, f_p0_rvalid}, re.port ? 2'b10 : 2'b01);
            cmp("fx_rdata", re.port ? f_p1_rdata : f_p0_rdata, re.data);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_r(input logic q0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                        input logic q1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
      r_p0_req = q0; r_p0_we = w0; r_p0_addr = a0; r_p0_wdata = d0;
      r_p1_req = q1; r_p1_we = w1; r_p1_addr = a1; r_p1_wdata = d1;
   endtask

   task automatic drv_f(input logic q0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                        input logic q1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
      f_p0_req = q0; f_p0_we = w0; f_p0_addr = a0; f_p0_wdata = d0;
      f_p1_req = q1; f_p1_we = w1; f_p1_addr = a1; f_p1_wdata = d1;
   endtask

   task automatic eg_r(input logic [1:0] g, input logic we, input logic [7:0] a, input logic [7:0] d);
      gq_r.push_back({g, we, a, d});
   endtask

   task automatic eg_f(input logic [1:0] g, input logic we, input logic [7:0] a, input logic [7:0] d);
      gq_f.push_back({g, we, a, d});
   endtask

   initial begin
      logic w;
      r_reset = 1'b1;
      f_reset = 1'b1;
      drv_r(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      drv_f(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

      // Reset held: requests must be ignored.
      cyc();
      drv_r(1, 0, 8'h02, 8'h00, 1, 0, 8'h03, 8'h00);
      drv_f(1, 0, 8'h04, 8'h00, 1, 0, 8'h05, 8'h00);
      eg_r(2'b00, 0, 8'h02, 8'h00);
      eg_f(2'b00, 0, 8'h04, 8'h00);

      // First cycle out of reset: port 0 read of 0x02 granted immediately.
      cyc();
      r_reset = 1'b0;
      f_reset = 1'b0;
      drv_r(1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 8'h00);
      drv_f(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      eg_r(2'b01, 0, 8'h02, 8'h00);
      rq_r.push_back({1'b0, 8'h02});
      eg_f(2'b00, 0, 8'h00, 8'h00);

      cyc();
      drv_r(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      eg_r(2'b00, 0, 8'h00, 8'h00);

      // Port 1 write 0x5A to 0x30, then port 0 reads it back.
      cyc();
      drv_r(0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 8'h5A);
      eg_r(2'b10, 1, 8'h30, 8'h5A);
      cyc();
      drv_r(1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00);
      eg_r(2'b01, 0, 8'h30, 8'h00);
      rq_r.push_back({1'b0, 8'h5A});
      cyc();
      drv_r(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      eg_r(2'b00, 0, 8'h00, 8'h00);

      // Both reading continuously; port 0 was served last, so port 1 takes the first tie.
      for (int i = 0; i < 6; i++) begin
         cyc();
         drv_r(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
         w = (i % 2 == 0);
         eg_r(w ? 2'b10 : 2'b01, 0, w ? 8'h20 : 8'h10, 8'h00);
         rq_r.push_back({w, w ? 8'h20 : 8'h10});
      end
      cyc();
      drv_r(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      eg_r(2'b00, 0, 8'h00, 8'h00);

      // Reset in the cycle after a read grant: that read never returns.
      cyc();
      drv_r(1, 0, 8'h07, 8'h00, 0, 0, 8'h00, 8'h00);
      eg_r(2'b01, 0, 8'h07, 8'h00);
      cyc();
      r_reset = 1'b1;
      drv_r(1, 0, 8'h11, 8'h00, 1, 0, 8'h22, 8'h00);
      eg_r(2'b00, 0, 8'h11, 8'h00);
      cyc();
      eg_r(2'b00, 0, 8'h11, 8'h00);
      for (int i = 0; i < 4; i++) begin
         cyc();
         r_reset = 1'b0;
         w = (i % 2 == 1);
         eg_r(w ? 2'b10 : 2'b01, 0, w ? 8'h22 : 8'h11, 8'h00);
         rq_r.push_back({w, w ? 8'h22 : 8'h11});
      end
      cyc();
      drv_r(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      eg_r(2'b00, 0, 8'h00, 8'h00);

      // Fixed priority, both held: port 1 forced through on cycles 4 and 9.
      for (int i = 0; i < 10; i++) begin
         cyc();
         drv_f(1, 0, 8'h40, 8'h00, 1, 0, 8'h41, 8'h00);
         w = (i == 4) || (i == 9);
         eg_f(w ? 2'b10 : 2'b01, 0, w ? 8'h41 : 8'h40, 8'h00);
         rq_f.push_back({w, w ? 8'h41 : 8'h40});
      end
      cyc();
      drv_f(0, 0, 8'h00, 8'h00, 1, 0, 8'h42, 8'h00);
      eg_f(2'b10, 0, 8'h42, 8'h00);
      rq_f.push_back({1'b1, 8'h42});
      cyc();
      drv_f(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      eg_f(2'b00, 0, 8'h00, 8'h00);

      cyc();
      cyc();
      cmp("rr_grant_queue_drained", gq_r.size(), 0);
      cmp("rr_read_queue_drained", rq_r.size(), 0);
      cmp("fx_grant_queue_drained", gq_f.size(), 0);
      cmp("fx_read_queue_drained", rq_f.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
